// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit.
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RD
  } lsu_state_e;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load shift/extend, misalignment.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);
  logic [31:0] shifted;

  always_comb begin
    shifted    = load_raw >> {addr_lo, 3'b000};
    be         = 4'b1111;
    wdata      = store_data;
    load_data  = shifted;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = sign_ext ? {{24{shifted[7]}}, shifted[7:0]} : {24'b0, shifted[7:0]};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_data  = sign_ext ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      // Reserved size 11 behaves exactly like a word access.
      default: begin
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: req/gnt/rvalid access FSM with load timeout, owns the M/W pipeline register.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  M_RegWrite,
  input  logic                  M_mem_write,
  input  logic [1:0]            M_type_control,
  input  logic                  M_sign_ext_flag,
  input  logic [1:0]            M_result_src,
  input  logic [DATA_WIDTH-1:0] M_alu_result,
  input  logic [DATA_WIDTH-1:0] M_write_data,
  input  logic [DATA_WIDTH-1:0] M_pc_out4,
  input  logic [4:0]            M_rd,
  input  logic [6:0]            M_opcode,
  output logic                  M_stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  W_RegWrite,
  output logic [1:0]            W_result_src,
  output logic [DATA_WIDTH-1:0] W_alu_result,
  output logic [DATA_WIDTH-1:0] W_read_data,
  output logic [DATA_WIDTH-1:0] W_pc_out4,
  output logic [4:0]            W_rd,
  output logic [6:0]            W_opcode,
  output logic                  W_misaligned,
  output logic                  W_bus_error
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e             state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic                   is_store, is_load, access, misaligned, fault_mis;
  logic                   req_c, stall_c, rd_done, timeout;
  logic [DATA_WIDTH-1:0]  load_data;

  assign is_store  = M_mem_write;
  assign is_load   = (M_result_src == RESULT_SRC_LOAD) && !M_mem_write;
  assign access    = is_store || (M_result_src == RESULT_SRC_LOAD);
  assign fault_mis = access && misaligned;

  lsu_align u_align (
    .addr_lo    (M_alu_result[1:0]),
    .size       (M_type_control),
    .sign_ext   (M_sign_ext_flag),
    .store_data (M_write_data),
    .load_raw   (mem_rdata),
    .be         (mem_be),
    .wdata      (mem_wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign mem_addr = {M_alu_result[DATA_WIDTH-1:2], 2'b00};
  // Reset gates the combinational handshake so nothing escapes while the FSM is being cleared.
  assign mem_req  = req_c && !rst;
  assign M_stall  = stall_c && !rst;
  assign mem_we   = mem_req && is_store;

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    rd_done   = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access && !misaligned) begin
          req_c = 1'b1;
          if (!(is_store && mem_gnt)) begin
            stall_c   = 1'b1;
            state_nxt = (is_load && mem_gnt) ? ST_WAIT_RD : ST_REQ;
          end
        end
      end
      ST_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (mem_gnt) begin
          if (is_store) begin
            stall_c   = 1'b0;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_WAIT_RD;
          end
        end
      end
      ST_WAIT_RD: begin
        stall_c = 1'b1;
        if (mem_rvalid) begin
          stall_c   = 1'b0;
          rd_done   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          stall_c   = 1'b0;
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Counter sits at zero outside WAIT_RD, so it is already clear on entry.
  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT_RD) cnt <= '0;
    else                            cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || stall_c) begin
      W_RegWrite   <= 1'b0;
      W_result_src <= '0;
      W_alu_result <= '0;
      W_read_data  <= '0;
      W_pc_out4    <= '0;
      W_rd         <= '0;
      W_opcode     <= '0;
      W_misaligned <= 1'b0;
      W_bus_error  <= 1'b0;
    end else begin
      W_RegWrite   <= M_RegWrite && !fault_mis && !timeout;
      W_result_src <= M_result_src;
      W_alu_result <= M_alu_result;
      W_read_data  <= rd_done ? load_data : '0;
      W_pc_out4    <= M_pc_out4;
      W_rd         <= M_rd;
      W_opcode     <= M_opcode;
      W_misaligned <= fault_mis;
      W_bus_error  <= timeout;
    end
  end
endmodule
